ddr3_rw_sched: RTL

- Command scheduler in front of the DDR3 memory interface user port.
- Arbitrates write bursts (drained from the write FIFO) and read bursts (filling the read FIFO) onto the single cmd/addr port.
- Generates linear addresses within programmable regions and manages ping-pong bank selection.
- Tracks outstanding reads so the read FIFO never overflows.

---
 rtl/ddr3_rw_sched.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/ddr3_rw_sched.sv
// rtl/ddr3_rw_sched.sv - DDR3 user-port read/write command scheduler
//
// Purpose: arbitrates write bursts (drained from the write FIFO) and read
// bursts (filling the read FIFO) onto the single app_* command port,
// generates linear addresses inside programmable regions with ping-pong
// bank selection, and limits outstanding reads to the read FIFO space.
//
// Ports:
//   ui_clk, rst_n                      clock, async active-low reset
//   init_calib_complete                gates all command issue
//   app_rdy, app_wdf_rdy               command / write-data ready
//   app_rd_data_valid                  read beat returned
//   app_en, app_cmd, app_addr          command valid / opcode / {bank,addr}
//   app_wdf_wren, app_wdf_end          write data valid (also wfifo read)
//   rfifo_wren                         read FIFO write enable
//   app_addr_wr_min/max, _rd_min/max   region bounds, max exclusive
//   wr_bust_len, rd_bust_len           beats per burst (0 acts as 1)
//   wfifo_rcount, rfifo_wcount         FIFO fill levels
//   ddr3_read_valid, ddr3_pingpang_en  read enable, ping-pong enable
//   wr_load, rd_load                   region reload requests (levels)
//   wr_bank, rd_bank, sched_busy       status
module ddr3_rw_sched #(
  parameter int ADDR_STEP   = 8,
  parameter int RFIFO_DEPTH = 512,
  parameter int OUT_W       = 10
) (
  input  logic        ui_clk,
  input  logic        rst_n,
  input  logic        init_calib_complete,
  input  logic        app_rdy,
  input  logic        app_wdf_rdy,
  input  logic        app_rd_data_valid,
  output logic        app_en,
  output logic [2:0]  app_cmd,
  output logic [28:0] app_addr,
  output logic        app_wdf_wren,
  output logic        app_wdf_end,
  output logic        rfifo_wren,
  input  logic [27:0] app_addr_wr_min,
  input  logic [27:0] app_addr_wr_max,
  input  logic [27:0] app_addr_rd_min,
  input  logic [27:0] app_addr_rd_max,
  input  logic [7:0]  wr_bust_len,
  input  logic [7:0]  rd_bust_len,
  input  logic [9:0]  wfifo_rcount,
  input  logic [9:0]  rfifo_wcount,
  input  logic        ddr3_read_valid,
  input  logic        ddr3_pingpang_en,
  input  logic        wr_load,
  input  logic        rd_load,
  output logic        wr_bank,
  output logic        rd_bank,
  output logic        sched_busy
);

  typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_WRITE, ST_READ} state_t;

  state_t           state_q, state_d;
  logic [27:0]      wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
  logic             wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [OUT_W-1:0] outstanding_q, outstanding_d;
  logic             last_rd_q, last_rd_d;
  logic             wr_load_q, rd_load_q;
  logic             wr_pend_q, wr_pend_d, rd_pend_q, rd_pend_d;

  logic [7:0]  wr_len, rd_len;
  logic [11:0] rd_space;
  logic        wr_ok, rd_ok, wr_acc, rd_acc, apply_wr, apply_rd;
  logic [28:0] wr_next, rd_next;
  logic        wr_wrap, rd_wrap;
  logic [8:0]  cnt_inc;

  assign wr_len = (wr_bust_len == 8'd0) ? 8'd1 : wr_bust_len;
  assign rd_len = (rd_bust_len == 8'd0) ? 8'd1 : rd_bust_len;

  // 12-bit difference so a negative free-space result shows up in bit 11.
  assign rd_space = 12'(RFIFO_DEPTH) - {2'b00, rfifo_wcount} - 12'(outstanding_q);
  assign wr_ok    = {2'b00, wfifo_rcount} >= {4'h0, wr_len};
  assign rd_ok    = ddr3_read_valid && !rd_space[11] && (rd_space[10:0] >= {3'b000, rd_len});

  assign wr_acc = (state_q == ST_WRITE) && init_calib_complete && app_rdy && app_wdf_rdy;
  assign rd_acc = (state_q == ST_READ) && init_calib_complete && app_rdy;

  assign wr_next = {1'b0, wr_addr_q} + 29'(ADDR_STEP);
  assign rd_next = {1'b0, rd_addr_q} + 29'(ADDR_STEP);
  assign wr_wrap = wr_next >= {1'b0, app_addr_wr_max};
  assign rd_wrap = rd_next >= {1'b0, app_addr_rd_max};
  assign cnt_inc = {1'b0, cnt_q} + 9'd1;

  // Pending loads are only applied between bursts so a burst is never cut.
  assign apply_wr = wr_pend_q && (state_q == ST_IDLE);
  assign apply_rd = rd_pend_q && (state_q == ST_IDLE);

  always_comb begin
    state_d       = state_q;
    wr_addr_d     = wr_addr_q;
    rd_addr_d     = rd_addr_q;
    wr_bank_d     = wr_bank_q;
    rd_bank_d     = rd_bank_q;
    cnt_d         = cnt_q;
    last_rd_d     = last_rd_q;
    outstanding_d = outstanding_q;
    wr_pend_d     = (wr_pend_q && !apply_wr) || (wr_load && !wr_load_q);
    rd_pend_d     = (rd_pend_q && !apply_rd) || (rd_load && !rd_load_q);

    if (!init_calib_complete) begin
      state_d = ST_INIT;
      cnt_d   = 8'd0;
    end else begin
      case (state_q)
        ST_INIT: state_d = ST_IDLE;
        ST_IDLE: begin
          // Both eligible: alternate against the previous grant.
          if (wr_ok && (!rd_ok || last_rd_q)) begin
            state_d   = ST_WRITE;
            last_rd_d = 1'b0;
          end else if (rd_ok) begin
            state_d   = ST_READ;
            last_rd_d = 1'b1;
          end
        end
        ST_WRITE: begin
          if (wr_acc) begin
            cnt_d = cnt_inc[7:0];
            if (wr_wrap) begin
              wr_addr_d = app_addr_wr_min;
              wr_bank_d = ddr3_pingpang_en ? ~wr_bank_q : 1'b0;
            end else begin
              wr_addr_d = wr_next[27:0];
            end
            if (cnt_inc >= {1'b0, wr_len}) begin
              cnt_d   = 8'd0;
              state_d = ST_IDLE;
            end
          end
        end
        ST_READ: begin
          if (rd_acc) begin
            cnt_d = cnt_inc[7:0];
            if (rd_wrap) begin
              rd_addr_d = app_addr_rd_min;
              // Read into the bank opposite the one currently being written.
              rd_bank_d = ddr3_pingpang_en ? ~wr_bank_q : 1'b0;
            end else begin
              rd_addr_d = rd_next[27:0];
            end
            if (cnt_inc >= {1'b0, rd_len}) begin
              cnt_d   = 8'd0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_INIT;
      endcase
    end

    if (apply_wr) begin
      wr_addr_d = app_addr_wr_min;
      wr_bank_d = 1'b0;
    end
    if (apply_rd) begin
      rd_addr_d = app_addr_rd_min;
      rd_bank_d = ddr3_pingpang_en;
    end

    if (rd_acc && !(app_rd_data_valid && outstanding_q != '0)) begin
      outstanding_d = outstanding_q + 1'b1;
    end else if (!rd_acc && app_rd_data_valid && outstanding_q != '0) begin
      outstanding_d = outstanding_q - 1'b1;
    end
  end

  always_ff @(posedge ui_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_INIT;
      wr_addr_q     <= 28'd0;
      rd_addr_q     <= 28'd0;
      wr_bank_q     <= 1'b0;
      rd_bank_q     <= 1'b0;
      cnt_q         <= 8'd0;
      last_rd_q     <= 1'b1;
      outstanding_q <= '0;
      wr_load_q     <= 1'b0;
      rd_load_q     <= 1'b0;
      wr_pend_q     <= 1'b0;
      rd_pend_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_addr_q     <= wr_addr_d;
      rd_addr_q     <= rd_addr_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      cnt_q         <= cnt_d;
      last_rd_q     <= last_rd_d;
      outstanding_q <= outstanding_d;
      wr_load_q     <= wr_load;
      rd_load_q     <= rd_load;
      wr_pend_q     <= wr_pend_d;
      rd_pend_q     <= rd_pend_d;
    end
  end

  always_comb begin
    app_en       = init_calib_complete && ((state_q == ST_WRITE) || (state_q == ST_READ));
    app_wdf_wren = init_calib_complete && (state_q == ST_WRITE);
    app_wdf_end  = app_wdf_wren;
    app_cmd      = (state_q == ST_READ) ? 3'b001 : 3'b000;
    app_addr     = 29'd0;
    if (state_q == ST_WRITE) app_addr = {wr_bank_q, wr_addr_q};
    if (state_q == ST_READ)  app_addr = {rd_bank_q, rd_addr_q};
  end

  assign rfifo_wren = app_rd_data_valid;
  assign wr_bank    = wr_bank_q;
  assign rd_bank    = rd_bank_q;
  assign sched_busy = (state_q == ST_WRITE) || (state_q == ST_READ);

endmodule
